// File: rtl/mult_shift_chain_if.sv
// Signal bundle between the multiplier controller and the {X,A,B} shift chain.
interface mult_shift_chain_if #(
  parameter int W = 8
);
  localparam int CW = $clog2(W + 1);

  logic          Load_B;
  logic          Clear_A;
  logic          Load_A;
  logic          Shift_En;
  logic [W-1:0]  Din;
  logic [W-1:0]  Sum;
  logic          Sum_X;
  logic          X_Out;
  logic [W-1:0]  A_Out;
  logic [W-1:0]  B_Out;
  logic          M;
  logic [CW-1:0] Shift_Count;
  logic          Done;

  // Controller side: drives commands and operands, samples the chain state.
  modport master (
    output Load_B, Clear_A, Load_A, Shift_En, Din, Sum, Sum_X,
    input  X_Out, A_Out, B_Out, M, Shift_Count, Done
  );

  // Chain side: receives commands and operands, presents its registers.
  modport slave (
    input  Load_B, Clear_A, Load_A, Shift_En, Din, Sum, Sum_X,
    output X_Out, A_Out, B_Out, M, Shift_Count, Done
  );
endinterface

// File: rtl/mult_shift_chain.sv
// {X,A,B} datapath register chain for a shift-add signed multiplier:
// per-segment load/clear, arithmetic right shift, shift counter and Done flag.
module mult_shift_chain #(
  parameter int W = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  mult_shift_chain_if.slave   bus
);
  localparam int CW = $clog2(W + 1);

  logic          r_x;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic          w_any_load;
  logic          w_shift;
  logic [CW-1:0] w_cnt_inc;

  // Any load/clear suppresses the shift completely, as does a finished count.
  always_comb begin
    w_any_load = bus.Load_B | bus.Clear_A | bus.Load_A;
    w_shift    = bus.Shift_En & ~r_done & ~w_any_load;
    w_cnt_inc  = r_cnt + CW'(1);
  end

  // X/A segment: clear beats load beats shift; X holds on shift (sign extension).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_x <= 1'b0;
      r_a <= '0;
    end else if (bus.Clear_A) begin
      r_x <= 1'b0;
      r_a <= '0;
    end else if (bus.Load_A) begin
      r_x <= bus.Sum_X;
      r_a <= bus.Sum;
    end else if (w_shift) begin
      r_a <= {r_x, r_a[W-1:1]};
    end
  end

  // B segment: load beats shift; A[0] enters the top, old B[0] drops out.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_b <= '0;
    end else if (bus.Load_B) begin
      r_b <= bus.Din;
    end else if (w_shift) begin
      r_b <= {r_a[0], r_b[W-1:1]};
    end
  end

  // Shift counter and registered Done; Done rises on the edge of the W-th shift.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (bus.Load_B) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (w_shift) begin
      r_cnt  <= w_cnt_inc;
      r_done <= (w_cnt_inc == CW'(W));
    end
  end

  assign bus.X_Out       = r_x;
  assign bus.A_Out       = r_a;
  assign bus.B_Out       = r_b;
  assign bus.M           = r_b[0];
  assign bus.Shift_Count = r_cnt;
  assign bus.Done        = r_done;
endmodule

// File: tb/tb_mult_shift_chain.sv
// Directed, table-driven bench for mult_shift_chain (W=8).
module tb_mult_shift_chain;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mult_shift_chain_if #(.W(W)) bus ();

  mult_shift_chain #(.W(W)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          lb;
    logic          ca;
    logic          la;
    logic          se;
    logic [W-1:0]  din;
    logic [W-1:0]  sum;
    logic          sx;
    logic          ex;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
    logic [CW-1:0] ecnt;
    logic          ed;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  task automatic chk1(input string nm, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic ex, input logic [W-1:0] ea,
                           input logic [W-1:0] eb, input logic [CW-1:0] ecnt, input logic ed);
    chk1("X_Out", idx, W'(bus.X_Out), W'(ex));
    chk1("A_Out", idx, bus.A_Out, ea);
    chk1("B_Out", idx, bus.B_Out, eb);
    chk1("M", idx, W'(bus.M), W'(eb[0]));
    chk1("Shift_Count", idx, W'(bus.Shift_Count), W'(ecnt));
    chk1("Done", idx, W'(bus.Done), W'(ed));
  endtask

  task automatic drive(input logic lb, input logic ca, input logic la, input logic se,
                       input logic [W-1:0] din, input logic [W-1:0] sum, input logic sx);
    bus.Load_B   = lb;
    bus.Clear_A  = ca;
    bus.Load_A   = la;
    bus.Shift_En = se;
    bus.Din      = din;
    bus.Sum      = sum;
    bus.Sum_X    = sx;
  endtask

  // One cycle: drive at negedge, sample 1 time unit after the rising edge.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    drive(v.lb, v.ca, v.la, v.se, v.din, v.sum, v.sx);
    @(posedge clk);
    #1;
    check_all(idx, v.ex, v.ea, v.eb, v.ecnt, v.ed);
  endtask

  initial begin
    errors = 0;
    checks = 0;

    //            lb ca la se  din    sum    sx  ex  ea     eb     cnt d
    // reset release, load B
    vecs[0]  = '{1, 0, 0, 0, 8'h5A, 8'h00, 0,  0, 8'h00, 8'h5A, 0, 0};
    // sign-preserving shift
    vecs[1]  = '{1, 0, 0, 0, 8'h03, 8'h00, 0,  0, 8'h00, 8'h03, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 8'h00, 8'h81, 1,  1, 8'h81, 8'h03, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  1, 8'hC0, 8'h81, 1, 0};
    // collisions
    vecs[4]  = '{0, 0, 1, 1, 8'h00, 8'h12, 0,  0, 8'h12, 8'h81, 1, 0};
    vecs[5]  = '{0, 1, 1, 0, 8'h00, 8'h34, 1,  0, 8'h00, 8'h81, 1, 0};
    // full multiply 7 * 3
    vecs[6]  = '{1, 1, 0, 0, 8'h07, 8'h00, 0,  0, 8'h00, 8'h07, 0, 0};
    vecs[7]  = '{0, 0, 1, 0, 8'h00, 8'h03, 0,  0, 8'h03, 8'h07, 0, 0};
    vecs[8]  = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h01, 8'h83, 1, 0};
    vecs[9]  = '{0, 0, 1, 0, 8'h00, 8'h04, 0,  0, 8'h04, 8'h83, 1, 0};
    vecs[10] = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h02, 8'h41, 2, 0};
    vecs[11] = '{0, 0, 1, 0, 8'h00, 8'h05, 0,  0, 8'h05, 8'h41, 2, 0};
    vecs[12] = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h02, 8'hA0, 3, 0};
    vecs[13] = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h01, 8'h50, 4, 0};
    vecs[14] = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h00, 8'hA8, 5, 0};
    vecs[15] = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h00, 8'h54, 6, 0};
    vecs[16] = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h00, 8'h2A, 7, 0};
    vecs[17] = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h00, 8'h15, 8, 1};
    // 9th shift ignored, count saturates
    vecs[18] = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h00, 8'h15, 8, 1};
    // A still loadable / clearable while Done
    vecs[19] = '{0, 0, 1, 0, 8'h00, 8'h7F, 0,  0, 8'h7F, 8'h15, 8, 1};
    vecs[20] = '{0, 1, 0, 1, 8'h00, 8'h00, 0,  0, 8'h00, 8'h15, 8, 1};
    // restart
    vecs[21] = '{1, 0, 0, 0, 8'hFF, 8'h00, 0,  0, 8'h00, 8'hFF, 0, 0};
    // idle cycle holds
    vecs[22] = '{0, 0, 0, 0, 8'h11, 8'h22, 1,  0, 8'h00, 8'hFF, 0, 0};
    // shift after restart: A=0,X=0 -> B={0,FF>>1}
    vecs[23] = '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h00, 8'h7F, 1, 0};

    // Reset held low with random inputs toggling
    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0, '0, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            W'($urandom), W'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      check_all(100 + int'(i), 0, 8'h00, 8'h00, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, '0, '0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // Async reset in the middle of a multiply after 4 shifts
    apply(200, '{1, 0, 0, 0, 8'hB6, 8'h00, 0,  0, 8'h00, 8'hB6, 0, 0});
    apply(201, '{0, 0, 1, 0, 8'h00, 8'h90, 1,  1, 8'h90, 8'hB6, 0, 0});
    apply(202, '{0, 0, 0, 1, 8'h00, 8'h00, 0,  1, 8'hC8, 8'h5B, 1, 0});
    apply(203, '{0, 0, 0, 1, 8'h00, 8'h00, 0,  1, 8'hE4, 8'h2D, 2, 0});
    apply(204, '{0, 0, 0, 1, 8'h00, 8'h00, 0,  1, 8'hF2, 8'h16, 3, 0});
    apply(205, '{0, 0, 0, 1, 8'h00, 8'h00, 0,  1, 8'hF9, 8'h0B, 4, 0});
    #2;
    rst_n = 1'b0;
    #1;
    check_all(206, 0, 8'h00, 8'h00, 0, 0);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, '0, '0, 0);
    apply(207, '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h00, 8'h00, 1, 0});
    apply(208, '{0, 0, 0, 1, 8'h00, 8'h00, 0,  0, 8'h00, 8'h00, 2, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
